// File: rtl/seg_pkg.sv
// Shared constants, glyph table and state type for the seven-segment formatter.
// Segment byte layout: bit0=A .. bit6=G, bit7=DP, active-high.
package seg_pkg;

    localparam int unsigned DIGIT_NUM = 8;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned SEG_W     = 8;
    localparam int unsigned GLYPH_W   = 7;
    localparam int unsigned VAL_W     = 32;
    localparam int unsigned IMG_W     = DIGIT_NUM * SEG_W;
    localparam int unsigned IDX_W     = 3;

    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
    localparam logic [SEG_W-1:0] SEG_DASH  = 8'h40;

    localparam logic [VAL_W-1:0] DEC_MAX = 32'd99_999_999;

    // Nibble-to-segment glyphs 0..F (b and d are lower-case shapes).
    localparam logic [GLYPH_W-1:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BCD    = 2'd1,
        ENCODE = 2'd2,
        COMMIT = 2'd3
    } fmt_state_t;

    function automatic logic [GLYPH_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nibble);
        return HEX_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift/add-3 iteration per cycle, 32 cycles.
// Ports:
//   clk, reset_n  - clock, async active-low reset
//   start         - load value and begin conversion (ignored while busy)
//   value         - 32-bit binary input
//   busy          - conversion iterations in progress
//   bcd           - eight BCD digits (low 32 bits of the BCD field), valid after done
//   done          - high during the final iteration cycle; bcd is valid from the next cycle
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    output logic             busy,
    output logic [VAL_W-1:0] bcd,
    output logic             done
);

    localparam int unsigned SHIFT_W = 2 * VAL_W;
    localparam int unsigned ITER_W  = 5;
    localparam logic [ITER_W-1:0] ITER_LAST = 5'd31;
    localparam logic [ITER_W-1:0] ITER_PRE  = 5'd30;

    logic [SHIFT_W-1:0] shift_q;
    logic [SHIFT_W-1:0] shift_step_c;
    logic [ITER_W-1:0]  iter_q;

    // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift left.
    always_comb begin
        shift_step_c = shift_q;
        for (int i = 0; i < int'(DIGIT_NUM); i++) begin
            if (shift_step_c[VAL_W + NIB_W*i +: NIB_W] >= 4'd5) begin
                shift_step_c[VAL_W + NIB_W*i +: NIB_W] =
                    shift_step_c[VAL_W + NIB_W*i +: NIB_W] + 4'd3;
            end
        end
        shift_step_c = {shift_step_c[SHIFT_W-2:0], 1'b0};
    end

    // Shift register, iteration counter and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            iter_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= busy && (iter_q == ITER_PRE);
            if (start && !busy) begin
                shift_q <= {VAL_W'(0), value};
                iter_q  <= '0;
                busy    <= 1'b1;
            end else if (busy) begin
                shift_q <= shift_step_c;
                iter_q  <= iter_q + ITER_W'(1);
                if (iter_q == ITER_LAST) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    assign bcd = shift_q[SHIFT_W-1:VAL_W];

endmodule

// File: rtl/seg_display_formatter.sv
// Renders a 32-bit value as an 8-digit seven-segment image (hex or unsigned
// decimal) with leading-zero blanking and a decimal-point mask. The image on
// digits only changes on a single-cycle commit, so the driver never sees a
// partially built image.
// Ports:
//   clk, reset_n             - clock, async active-low reset
//   in_valid / in_ready      - request handshake; ready only while idle
//   in_value, in_mode        - value and format (0 hex, 1 unsigned decimal)
//   in_blank_lz, in_dp       - leading-zero blanking, per-digit DP mask
//   digits                   - 64-bit segment image, byte i = digit i (0 rightmost)
//   busy                     - conversion in progress
//   done                     - one-cycle pulse when a new image first appears
module seg_display_formatter
    import seg_pkg::*;
#(
    parameter logic [7:0] OVF_PATTERN = SEG_DASH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] in_value,
    input  logic             in_mode,
    input  logic             in_blank_lz,
    input  logic [7:0]       in_dp,
    output logic [IMG_W-1:0] digits,
    output logic             busy,
    output logic             done
);

    fmt_state_t state_q;
    fmt_state_t state_next_c;

    logic [VAL_W-1:0]     val_q;
    logic                 mode_q;
    logic                 blank_q;
    logic [DIGIT_NUM-1:0] dp_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 nz_q;
    logic [IMG_W-1:0]     stage_q;

    logic accept_c;
    logic ovf_c;
    logic bcd_start_c;
    logic ovf_load_c;
    logic enc_load_c;
    logic enc_step_c;
    logic commit_c;

    logic [VAL_W-1:0]   src_c;
    logic [NIB_W-1:0]   nib_c;
    logic               nz_now_c;
    logic [GLYPH_W-1:0] seg_c;
    logic [SEG_W-1:0]   byte_c;

    logic [VAL_W-1:0] bcd_digits;
    logic             bcd_done;
    logic             bcd_busy_unused;

    assign accept_c = in_valid && in_ready;
    assign ovf_c    = in_mode && (in_value > DEC_MAX);

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (bcd_start_c),
        .value   (in_value),
        .busy    (bcd_busy_unused),
        .bcd     (bcd_digits),
        .done    (bcd_done)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next_c;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_c = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (!in_mode) begin
                        state_next_c = ENCODE;
                    end else if (ovf_c) begin
                        state_next_c = COMMIT;
                    end else begin
                        state_next_c = BCD;
                    end
                end
            end
            BCD: begin
                if (bcd_done) begin
                    state_next_c = ENCODE;
                end
            end
            ENCODE: begin
                if (idx_q == IDX_W'(0)) begin
                    state_next_c = COMMIT;
                end
            end
            COMMIT:  state_next_c = IDLE;
            default: state_next_c = IDLE;
        endcase
    end

    // Control strobes decoded from state.
    always_comb begin
        bcd_start_c = 1'b0;
        ovf_load_c  = 1'b0;
        enc_load_c  = 1'b0;
        enc_step_c  = 1'b0;
        commit_c    = 1'b0;
        if (state_q == IDLE && accept_c) begin
            bcd_start_c = in_mode && !ovf_c;
            ovf_load_c  = ovf_c;
        end
        if (state_next_c == ENCODE && state_q != ENCODE) begin
            enc_load_c = 1'b1;
        end
        if (state_q == ENCODE) begin
            enc_step_c = 1'b1;
        end
        if (state_q == COMMIT) begin
            commit_c = 1'b1;
        end
    end

    // Per-digit encode: nz_now_c is the sticky flag including this nibble, so a
    // zero nibble is blanked only when every more-significant digit was zero.
    always_comb begin
        src_c    = mode_q ? bcd_digits : val_q;
        nib_c    = src_c[{idx_q, 2'b00} +: NIB_W];
        nz_now_c = nz_q || (nib_c != NIB_W'(0));
        if (blank_q && !nz_now_c && (idx_q != IDX_W'(0))) begin
            seg_c = SEG_BLANK[GLYPH_W-1:0];
        end else begin
            seg_c = hex_to_seg(nib_c);
        end
        byte_c = {dp_q[idx_q], seg_c};
    end

    // Request capture, staging image, committed image and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_q    <= '0;
            mode_q   <= 1'b0;
            blank_q  <= 1'b0;
            dp_q     <= '0;
            idx_q    <= '0;
            nz_q     <= 1'b0;
            stage_q  <= '0;
            digits   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            busy     <= (state_next_c != IDLE);
            in_ready <= (state_next_c == IDLE);
            done     <= commit_c;
            if (accept_c) begin
                val_q   <= in_value;
                mode_q  <= in_mode;
                blank_q <= in_blank_lz;
                dp_q    <= in_dp;
            end
            if (ovf_load_c) begin
                stage_q <= {DIGIT_NUM{OVF_PATTERN}};
            end
            if (enc_load_c) begin
                idx_q <= IDX_W'(DIGIT_NUM - 1);
                nz_q  <= 1'b0;
            end else if (enc_step_c) begin
                stage_q[{idx_q, 3'b000} +: SEG_W] <= byte_c;
                nz_q  <= nz_now_c;
                idx_q <= idx_q - IDX_W'(1);
            end
            if (commit_c) begin
                digits <= stage_q;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_formatter.sv
// Self-checking bench for seg_display_formatter: directed cases plus
// randomized requests checked against an arithmetic reference model.
module tb_seg_display_formatter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        in_mode;
    logic        in_blank_lz;
    logic [7:0]  in_dp;
    logic [63:0] digits;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Image the bench expects to be on display between commits.
    logic [63:0] shown;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    seg_display_formatter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_mode     (in_mode),
        .in_blank_lz (in_blank_lz),
        .in_dp       (in_dp),
        .digits      (digits),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference image: digit values by division, blanking above the most
    // significant nonzero digit.
    function automatic logic [63:0] model_image(input logic [31:0] v, input logic m,
                                                input logic b, input logic [7:0] dp);
        int unsigned dig [8];
        longint unsigned r;
        int msd;
        logic [6:0] seg;
        logic [63:0] img;
        if (m && v > 32'd99_999_999) return {8{8'h40}};
        r = longint'(v);
        for (int i = 0; i < 8; i++) begin
            dig[i] = m ? int'(r % 10) : int'(r % 16);
            r      = m ? r / 10 : r / 16;
        end
        msd = 0;
        for (int i = 0; i < 8; i++) if (dig[i] != 0) msd = i;
        img = '0;
        for (int i = 0; i < 8; i++) begin
            seg = GLYPH[dig[i]];
            if (b && i > msd) seg = 7'h00;
            img[i*8 +: 8] = {dp[i], seg};
        end
        return img;
    endfunction

    function automatic int model_latency(input logic [31:0] v, input logic m);
        if (!m) return 10;
        if (v > 32'd99_999_999) return 2;
        return 42;
    endfunction

    // Present one request; returns in cycle T+1 with in_valid dropped.
    task automatic send(input logic [31:0] v, input logic m, input logic b, input logic [7:0] dp);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_req", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_value    = v;
        in_mode     = m;
        in_blank_lz = b;
        in_dp       = dp;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_value = $urandom;
        in_mode  = 1'($urandom_range(0, 1));
        in_dp    = 8'($urandom);
    endtask

    // Called in cycle T+1; returns in the done cycle.
    task automatic await_done(input string tag, input int lat, input logic [63:0] img);
        int n = 1;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_notready"}, 64'(in_ready), 64'd0);
        while (!done && n < 80) begin
            check({tag, "_hold"}, digits, shown);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_img"}, digits, img);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        shown = img;
    endtask

    // One cycle after done: pulse must be gone, image held.
    task automatic after_done(input string tag);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_keep"}, digits, shown);
    endtask

    task automatic run_req(input string tag, input logic [31:0] v, input logic m,
                           input logic b, input logic [7:0] dp, input logic [63:0] img);
        send(v, m, b, dp);
        await_done(tag, model_latency(v, m), img);
        after_done(tag);
    endtask

    initial begin
        logic [31:0] v;
        logic        m, b;
        logic [7:0]  dp;
        int          sel;

        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_value    = '0;
        in_mode     = 1'b0;
        in_blank_lz = 1'b0;
        in_dp       = '0;
        shown       = '0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;

        check("rst_digits", digits, 64'h0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        run_req("hex_a5", 32'h0000_00A5, 1'b0, 1'b1, 8'h00, 64'h0000_0000_0000_776D);
        run_req("dec_12345678", 32'd12345678, 1'b1, 1'b0, 8'h00, 64'h065B_4F66_6D7D_077F);
        run_req("dec_zero", 32'd0, 1'b1, 1'b1, 8'h04, 64'h0000_0000_0080_003F);
        run_req("dec_ovf", 32'd100_000_000, 1'b1, 1'b1, 8'hFF, 64'h4040_4040_4040_4040);
        run_req("dec_max", 32'd99_999_999, 1'b1, 1'b1, 8'h00, 64'h6F6F_6F6F_6F6F_6F6F);

        // Back-to-back: valid held high, second value queued while busy.
        in_valid    = 1'b1;
        in_value    = 32'h1;
        in_mode     = 1'b0;
        in_blank_lz = 1'b1;
        in_dp       = 8'h00;
        @(posedge clk); #1;
        in_value = 32'h2;
        await_done("b2b_first", 10, 64'h06);
        @(posedge clk); #1;
        in_valid = 1'b0;
        await_done("b2b_second", 10, 64'h5B);
        after_done("b2b_second");

        // Reset during the BCD phase.
        send(32'd5, 1'b1, 1'b0, 8'h00);
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_digits", digits, 64'h0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_done", 64'(done), 64'd0);
        shown = '0;
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;
        run_req("post_rst_ffff", 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00, 64'h7171_7171_7171_7171);

        // Randomized requests against the reference model.
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       v = $urandom;
                1:       v = 32'($urandom_range(0, 999));
                2:       v = 32'd99_999_998 + 32'($urandom_range(0, 3));
                default: v = $urandom >> $urandom_range(0, 31);
            endcase
            m  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            dp = 8'($urandom);
            run_req("rand", v, m, b, dp, model_image(v, m, b, dp));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
